fetch_stage: RTL

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/riscv_pkg.sv | 6 +
 rtl/fetch_stage_if.sv | 10 +
 rtl/pc_reg.sv | 21 ++
 rtl/fetch_stage.sv | 72 +++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32 constants for the front end: datapath width, canonical NOP and default boot PC.
package riscv_pkg;
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory port: fetch drives the byte address, memory answers combinationally.
interface fetch_stage_if;
    import riscv_pkg::*;

    logic [XLEN-1:0] imem_addr;
    logic [XLEN-1:0] imem_rdata;

    modport master (output imem_addr, input imem_rdata);
    modport slave  (input imem_addr, output imem_rdata);
endinterface

// File: rtl/pc_reg.sv
// Program counter register: loads load_value when en is high, otherwise holds.
module pc_reg
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [XLEN-1:0] load_value,
    output logic [XLEN-1:0] pc
);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc <= RESET_PC;
        end else if (en) begin
            // NOTE: non-blocking so every flop samples pre-edge values regardless of block order.
            pc <= load_value;
        end
    end
endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: next-PC selection, IF/ID pipeline register and fetched-instruction counter.
module fetch_stage
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_f,
    input  logic              stall_d,
    input  logic              flush_d,
    input  logic              redirect_e,
    input  logic [XLEN-1:0]   redirect_target_e,
    fetch_stage_if.master     imem,
    output logic [XLEN-1:0]   instr_d,
    output logic [XLEN-1:0]   pc_d,
    output logic [XLEN-1:0]   pc_plus4_d,
    output logic              valid_d,
    output logic              misalign_e,
    output logic [XLEN-1:0]   fetch_count
);
    logic [XLEN-1:0] pc_f;
    logic [XLEN-1:0] pc_plus4_f;
    logic [XLEN-1:0] pc_next;
    logic            pc_en;
    logic            squash_d;

    assign pc_plus4_f     = pc_f + 32'd4;
    assign imem.imem_addr = pc_f;
    assign misalign_e     = redirect_e && (redirect_target_e[1:0] != 2'b00);
    assign squash_d       = flush_d || redirect_e;

    always_comb begin
        // NOTE: defaults first on every path so no latch is inferred.
        pc_next = pc_plus4_f;
        pc_en   = !stall_f;
        if (redirect_e) begin
            // Misaligned targets still redirect; the low bits are simply dropped.
            pc_next = {redirect_target_e[XLEN-1:2], 2'b00};
            pc_en   = 1'b1;
        end
    end

    pc_reg #(.RESET_PC(RESET_PC)) u_pc_reg (
        .clk        (clk),
        .rst        (rst),
        .en         (pc_en),
        .load_value (pc_next),
        .pc         (pc_f)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instr_d     <= NOP_INSTR;
            pc_d        <= '0;
            pc_plus4_d  <= '0;
            valid_d     <= 1'b0;
            fetch_count <= '0;
        end else if (squash_d) begin
            instr_d    <= NOP_INSTR;
            pc_d       <= pc_f;
            pc_plus4_d <= pc_plus4_f;
            valid_d    <= 1'b0;
        end else if (!stall_d) begin
            instr_d     <= imem.imem_rdata;
            pc_d        <= pc_f;
            pc_plus4_d  <= pc_plus4_f;
            valid_d     <= 1'b1;
            fetch_count <= fetch_count + 32'd1;
        end
    end
endmodule
